// File: rtl/keypad_event_sequencer_pkg.sv
// Shared definitions for the keypad event sequencer.
// Holds the key width, the FSM state encoding and the key-field check
// used when a captured key is classified as valid or invalid.
package keypad_event_sequencer_pkg;

  localparam int KEY_W = 4;

  // A row or column field of 3 does not exist on the 3x3 keypad.
  localparam logic [1:0] INVALID_FIELD = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CLEAR   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  // key = {column[1:0], row[1:0]}
  function automatic logic key_is_invalid(input logic [KEY_W-1:0] k);
    return (k[3:2] == INVALID_FIELD) || (k[1:0] == INVALID_FIELD);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO.
// Ports:
//   clk, reset   clock, synchronous active-high reset (empties the FIFO)
//   push, din    write request and data
//   pop          read request; head advances at the clock edge
//   dout         head entry, driven from the registered array
//   count        occupancy, 0..DEPTH
//   full, empty  occupancy flags, decoded from the registered count
// push while full is only honoured together with a pop; pop while empty
// is ignored, so the count never leaves 0..DEPTH.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage has no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_sequencer.sv
// Keypad event sequencer.
// Synchronizes valid_key from the keypad controller, captures each press
// as exactly one key event, pulses the controller's active-low clear and
// waits for the key to be released for HOLDOFF_CYCLES before re-arming.
// Events are queued in a FWFT FIFO drained with ev_valid/ev_ready.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   enable        gates acceptance of new presses only
//   valid_key,key keypad controller outputs (valid_key is asynchronous)
//   kp_clear_n    registered active-low clear back to the controller
//   ev_valid/ev_key/ev_ready  event stream to the game logic
//   fifo_count    event FIFO occupancy
//   overflow      sticky: a valid press was dropped on a full FIFO
//   invalid_key   one-cycle pulse: captured key had column or row of 3
//   clear_flags   clears overflow
module keypad_event_sequencer
  import keypad_event_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int CLEAR_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         valid_key,
  input  logic [KEY_W-1:0]             key,
  output logic                         kp_clear_n,
  output logic                         ev_valid,
  output logic [KEY_W-1:0]             ev_key,
  input  logic                         ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         invalid_key,
  input  logic                         clear_flags
);

  localparam int CNT_MAX = (CLEAR_CYCLES > HOLDOFF_CYCLES) ? CLEAR_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             vk_meta, vk_s;
  logic             push, pop, drop, bad_key;
  logic             full, empty;

  // Two-flop synchronizer; key itself is only sampled once vk_s is high,
  // by which time the controller holds it stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      vk_meta <= 1'b0;
      vk_s    <= 1'b0;
    end else begin
      vk_meta <= valid_key;
      vk_s    <= vk_meta;
    end
  end

  assign pop = ev_ready & ~empty;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    push       = 1'b0;
    drop       = 1'b0;
    bad_key    = 1'b0;
    case (state)
      IDLE: begin
        if (vk_s && enable) next_state = CAPTURE;
      end
      CAPTURE: begin
        // A pop in this same cycle frees a slot, so a full FIFO still
        // accepts the new event.
        if (key_is_invalid(key)) bad_key = 1'b1;
        else if (full && !pop)   drop    = 1'b1;
        else                     push    = 1'b1;
        next_state = CLEAR;
        cnt_next   = CLEAR_LOAD;
      end
      CLEAR: begin
        if (cnt == '0) begin
          next_state = HOLDOFF;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        // Any bounce back to high restarts the release window.
        if (vk_s)            cnt_next   = HOLD_LOAD;
        else if (cnt == '0)  next_state = IDLE;
        else                 cnt_next   = cnt - CNT_W'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      kp_clear_n  <= 1'b1;
      invalid_key <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      kp_clear_n  <= (next_state != CLEAR);
      invalid_key <= bad_key;
      // Set wins over a simultaneous clear.
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (key),
    .pop   (pop),
    .dout  (ev_key),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign ev_valid = ~empty;

endmodule

// File: tb/tb_keypad_event_sequencer.sv
// Self-checking bench for keypad_event_sequencer with a queue-based
// event model. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled at the same point.
module tb_keypad_event_sequencer;
  import keypad_event_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CLR   = 4;
  localparam int HOLD  = 10;

  logic       clk = 1'b0;
  logic       reset, enable, valid_key, ev_ready, clear_flags;
  logic [3:0] key, ev_key;
  logic       kp_clear_n, ev_valid, overflow, invalid_key;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] mq[$];
  bit         m_ovf;

  always #5 clk = ~clk;

  keypad_event_sequencer #(
    .FIFO_DEPTH(DEPTH), .CLEAR_CYCLES(CLR), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .valid_key(valid_key),
    .key(key), .kp_clear_n(kp_clear_n), .ev_valid(ev_valid),
    .ev_key(ev_key), .ev_ready(ev_ready), .fifo_count(fifo_count),
    .overflow(overflow), .invalid_key(invalid_key), .clear_flags(clear_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit key_bad(input logic [3:0] k);
    return (k[3:2] == 2'd3) || (k[1:0] == 2'd3);
  endfunction

  function automatic logic [3:0] rand_valid_key();
    logic [1:0] c, r;
    c = 2'($urandom_range(0, 2));
    r = 2'($urandom_range(0, 2));
    return {c, r};
  endfunction

  // Drives one press and reports what was seen on kp_clear_n / invalid_key.
  // Cycle t is the state after edge t, with valid_key rising just after edge 0.
  task automatic press(input logic [3:0] k, input bit en, input int hold, input bit pop_cap,
                       output int clr_cnt, output int clr_first, output int inv_cnt);
    clr_cnt = 0; clr_first = -1; inv_cnt = 0;
    enable = en; key = k; valid_key = 1'b1;
    for (int t = 1; t <= hold + 14; t++) begin
      if (t == hold + 1) valid_key = 1'b0;
      ev_ready = pop_cap && (t == 4);
      tick();
      if (!kp_clear_n) begin
        clr_cnt++;
        if (clr_first < 0) clr_first = t;
      end
      if (invalid_key) inv_cnt++;
    end
    ev_ready = 1'b0;
  endtask

  function automatic void model_press(input logic [3:0] k, input bit en);
    if (!en || key_bad(k)) return;
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(k);
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; valid_key = 1'b0; key = '0;
    ev_ready = 1'b0; clear_flags = 1'b0;
    tick(); tick();
    n_cmp++; if (kp_clear_n !== 1'b1) begin n_bad++; $display("FAIL reset_kp_clear_n: got %b want 1", kp_clear_n); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (invalid_key !== 1'b0) begin n_bad++; $display("FAIL reset_invalid: got %b want 0", invalid_key); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    reset = 1'b0;
    tick();
    mq.delete(); m_ovf = 1'b0;
  endtask

  // Held press: event at cycle 4, clear low cycles 4..7, one event only,
  // IDLE 10 cycles after the synchronized release.
  task automatic test_single_press();
    key = 4'b0110; enable = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      valid_key = (t <= 20);
      tick();
      n_cmp++; if (ev_valid !== (t >= 4)) begin n_bad++; $display("FAIL single_ev_valid t=%0d: got %b want %b", t, ev_valid, t >= 4); end
      n_cmp++; if (kp_clear_n !== !(t >= 4 && t <= 7)) begin n_bad++; $display("FAIL single_clear t=%0d: got %b want %b", t, kp_clear_n, !(t >= 4 && t <= 7)); end
      if (t >= 4) begin
        n_cmp++; if (ev_key !== 4'h6) begin n_bad++; $display("FAIL single_ev_key t=%0d: got %0h want 6", t, ev_key); end
      end
      if (t == 31) begin
        n_cmp++; if (dut.state !== HOLDOFF) begin n_bad++; $display("FAIL single_holdoff: got %0d want %0d", dut.state, HOLDOFF); end
      end
      if (t == 32) begin
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL single_idle: got %0d want %0d", dut.state, IDLE); end
      end
    end
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_overflow();
    logic [3:0] keys [5];
    int cc, cf, ic;
    keys = '{4'd4, 4'd1, 4'd5, 4'd2, 4'd9};
    foreach (keys[i]) begin
      press(keys[i], 1'b1, 8, 1'b0, cc, cf, ic);
      model_press(keys[i], 1'b1);
      n_cmp++; if (fifo_count !== 3'(mq.size())) begin n_bad++; $display("FAIL ovf_count[%0d]: got %0d want %0d", i, fifo_count, mq.size()); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    while (mq.size() > 0) begin
      n_cmp++; if (ev_key !== mq[0]) begin n_bad++; $display("FAIL ovf_order: got %0h want %0h", ev_key, mq[0]); end
      ev_ready = 1'b1; tick(); ev_ready = 1'b0;
      void'(mq.pop_front());
    end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b want 0", ev_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0; m_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_invalid();
    int cc, cf, ic;
    press(4'b1101, 1'b1, 8, 1'b0, cc, cf, ic);
    n_cmp++; if (ic !== 1) begin n_bad++; $display("FAIL inv_pulses: got %0d want 1", ic); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL inv_count: got %0d want 0", fifo_count); end
    n_cmp++; if (cc !== CLR) begin n_bad++; $display("FAIL inv_clear_len: got %0d want %0d", cc, CLR); end
    n_cmp++; if (cf !== 4) begin n_bad++; $display("FAIL inv_clear_start: got %0d want 4", cf); end
  endtask

  // Full FIFO, consumer pops in the capture cycle: push and pop both happen.
  task automatic test_full_pop();
    int cc, cf, ic;
    logic [3:0] k;
    for (int i = 0; i < DEPTH; i++) begin
      k = rand_valid_key();
      press(k, 1'b1, 7, 1'b0, cc, cf, ic);
      model_press(k, 1'b1);
    end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fullpop_fill: got %0d want 4", fifo_count); end
    press(4'b0010, 1'b1, 7, 1'b1, cc, cf, ic);
    void'(mq.pop_front());
    mq.push_back(4'b0010);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fullpop_count: got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
    while (mq.size() > 0) begin
      n_cmp++; if (ev_key !== mq[0]) begin n_bad++; $display("FAIL fullpop_order: got %0h want %0h", ev_key, mq[0]); end
      ev_ready = 1'b1; tick(); ev_ready = 1'b0;
      void'(mq.pop_front());
    end
  endtask

  task automatic test_enable();
    enable = 1'b0; key = 4'b0110; valid_key = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      n_cmp++; if (kp_clear_n !== 1'b1 || ev_valid !== 1'b0) begin n_bad++; $display("FAIL en_off t=%0d: got clr=%b ev=%b want 1/0", t, kp_clear_n, ev_valid); end
    end
    // vk_s is already high, so capture follows one edge after enable rises.
    enable = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      n_cmp++; if (kp_clear_n !== !(t >= 2 && t <= 5)) begin n_bad++; $display("FAIL en_on_clear t=%0d: got %b want %b", t, kp_clear_n, !(t >= 2 && t <= 5)); end
      n_cmp++; if (ev_valid !== (t >= 2)) begin n_bad++; $display("FAIL en_on_ev t=%0d: got %b want %b", t, ev_valid, t >= 2); end
    end
    valid_key = 1'b0;
    for (int t = 0; t < 14; t++) tick();
    n_cmp++; if (fifo_count !== 3'd1 || ev_key !== 4'h6) begin n_bad++; $display("FAIL en_event: got cnt=%0d key=%0h want 1/6", fifo_count, ev_key); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cc, cf, ic;
    logic [3:0] k;
    for (int i = 0; i < 2; i++) begin
      k = rand_valid_key();
      press(k, 1'b1, 6, 1'b0, cc, cf, ic);
      model_press(k, 1'b1);
    end
    enable = 1'b1; key = 4'b0101; valid_key = 1'b1;
    for (int t = 1; t <= 5; t++) tick();
    n_cmp++; if (kp_clear_n !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_clear: got %b want 0", kp_clear_n); end
    reset = 1'b1; valid_key = 1'b0;
    tick();
    n_cmp++; if (kp_clear_n !== 1'b1) begin n_bad++; $display("FAIL rstmid_clear_n: got %b want 1", kp_clear_n); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ev_valid: got %b want 0", ev_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d want %0d", dut.state, IDLE); end
    reset = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    int cc, cf, ic, hold, np;
    logic [3:0] k;
    bit en;
    for (int i = 0; i < 12; i++) begin
      k    = 4'($urandom_range(0, 15));
      en   = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(6, 12);
      press(k, en, hold, 1'b0, cc, cf, ic);
      model_press(k, en);
      n_cmp++; if (cc !== (en ? CLR : 0)) begin n_bad++; $display("FAIL rnd_clear[%0d]: got %0d want %0d", i, cc, en ? CLR : 0); end
      n_cmp++; if (ic !== ((en && key_bad(k)) ? 1 : 0)) begin n_bad++; $display("FAIL rnd_invalid[%0d]: got %0d key=%0h en=%b", i, ic, k, en); end
      n_cmp++; if (fifo_count !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, fifo_count, mq.size()); end
      n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_overflow[%0d]: got %b want %b", i, overflow, m_ovf); end
      np = $urandom_range(0, 2);
      for (int j = 0; j < np; j++) begin
        if (mq.size() > 0) begin
          n_cmp++; if (ev_key !== mq[0]) begin n_bad++; $display("FAIL rnd_head[%0d]: got %0h want %0h", i, ev_key, mq[0]); end
        end
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_flags = 1'b1; tick(); clear_flags = 1'b0; m_ovf = 1'b0;
      end
    end
    n_cmp++; if (fifo_count !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_final_count: got %0d want %0d", fifo_count, mq.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_overflow();
    test_invalid();
    test_full_pop();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
